// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and overflow/underflow reporting.
// Illegal pushes (full) and pops (empty) are dropped and flagged; err_sticky latches any violation.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_fifo_full,
    output logic                       o_fifo_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow,
    output logic                       o_err_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_err_sticky;

    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_ovf_next;
    logic             w_udf_next;
    logic [CW-1:0]    w_count_next;

    // A pop frees a slot on the same edge, so a full FIFO may still accept a push alongside it.
    assign w_pop_acc  = i_pop && !r_empty;
    assign w_push_acc = i_push && (!r_full || w_pop_acc);
    assign w_ovf_next = i_push && !w_push_acc;
    assign w_udf_next = i_pop && r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            r_rd_valid   <= w_pop_acc;
            r_count      <= w_count_next;
            r_full       <= (w_count_next == CW'(DEPTH));
            r_empty      <= (w_count_next == '0);
            r_overflow   <= w_ovf_next;
            r_underflow  <= w_udf_next;
            r_err_sticky <= r_err_sticky | w_ovf_next | w_udf_next;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_fifo_full  = r_full;
    assign o_fifo_empty = r_empty;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_underflow  = r_underflow;
    assign o_err_sticky = r_err_sticky;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (WIDTH=8, DEPTH=16): fill/drain, overflow, underflow,
// simultaneous push/pop at the boundaries, a mixed run against a queue, and async reset.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_push;
    logic [7:0] i_wr_data;
    logic       i_pop;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_fifo_full;
    logic       o_fifo_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_underflow;
    logic       o_err_sticky;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] m_rd;

    sync_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (i_push),
        .i_wr_data    (i_wr_data),
        .i_pop        (i_pop),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_fifo_full  (o_fifo_full),
        .o_fifo_empty (o_fifo_empty),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow),
        .o_err_sticky (o_err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request for one edge, then sample 1 time unit after that edge.
    task automatic drive(input logic p, input logic [7:0] d, input logic q);
        i_push    = p;
        i_wr_data = d;
        i_pop     = q;
        @(posedge clk);
        #1;
        i_push = 1'b0;
        i_pop  = 1'b0;
    endtask

    task automatic mstep(input logic p, input logic [7:0] d, input logic q);
        logic pa, wa, eo, eu;
        int   sz;
        sz = mq.size();
        pa = q && (sz > 0);
        wa = p && ((sz < 16) || pa);
        eo = p && !wa;
        eu = q && (sz == 0);
        if (pa) m_rd = mq.pop_front();
        if (wa) mq.push_back(d);
        drive(p, d, q);
        chk("m_rd_valid",  32'(o_rd_valid),   32'(pa));
        chk("m_rd_data",   32'(o_rd_data),    32'(m_rd));
        chk("m_count",     32'(o_count),      32'(mq.size()));
        chk("m_overflow",  32'(o_overflow),   32'(eo));
        chk("m_underflow", 32'(o_underflow),  32'(eu));
        chk("m_full",      32'(o_fifo_full),  32'(mq.size() == 16));
        chk("m_empty",     32'(o_fifo_empty), 32'(mq.size() == 0));
    endtask

    initial begin
        rst_n     = 1'b0;
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: idle after reset
        drive(1'b0, 8'h00, 1'b0);
        chk("rst_empty",  32'(o_fifo_empty), 32'd1);
        chk("rst_full",   32'(o_fifo_full),  32'd0);
        chk("rst_count",  32'(o_count),      32'd0);
        chk("rst_ovf",    32'(o_overflow),   32'd0);
        chk("rst_udf",    32'(o_underflow),  32'd0);
        chk("rst_err",    32'(o_err_sticky), 32'd0);
        chk("rst_rvalid", 32'(o_rd_valid),   32'd0);
        chk("rst_rdata",  32'(o_rd_data),    32'd0);

        // 2: fill 0x01..0x10, then drain in order
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            chk("fill_count", 32'(o_count),      32'(i));
            chk("fill_full",  32'(o_fifo_full),  32'(i == 16));
            chk("fill_empty", 32'(o_fifo_empty), 32'd0);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("drain_data",  32'(o_rd_data),    32'(i));
            chk("drain_valid", 32'(o_rd_valid),   32'd1);
            chk("drain_count", 32'(o_count),      32'(16 - i));
            chk("drain_empty", 32'(o_fifo_empty), 32'(i == 16));
        end

        // 3: overflow
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(o_overflow),   32'd1);
        chk("ovf_err",   32'(o_err_sticky), 32'd1);
        chk("ovf_count", 32'(o_count),      32'd16);
        chk("ovf_full",  32'(o_fifo_full),  32'd1);
        drive(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(o_overflow),   32'd0);
        chk("ovf_stick", 32'(o_err_sticky), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk("ovf_drain", 32'(o_rd_data), 32'(i));
        end

        // 4: underflow; rd_data keeps 0x10
        drive(1'b0, 8'h00, 1'b1);
        chk("udf_pulse", 32'(o_underflow),  32'd1);
        chk("udf_valid", 32'(o_rd_valid),   32'd0);
        chk("udf_data",  32'(o_rd_data),    32'h10);
        chk("udf_count", 32'(o_count),      32'd0);
        chk("udf_err",   32'(o_err_sticky), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        chk("udf_clear", 32'(o_underflow),  32'd0);

        // 5: simultaneous push/pop at full and empty, then mixed traffic
        m_rd = 8'h10;
        for (int i = 0; i < 16; i++) mstep(1'b1, 8'(8'h20 + i), 1'b0);
        mstep(1'b1, 8'h55, 1'b1);
        chk("full_pp_data", 32'(o_rd_data), 32'h20);
        chk("full_pp_ovf",  32'(o_overflow), 32'd0);
        for (int i = 0; i < 16; i++) mstep(1'b0, 8'h00, 1'b1);
        mstep(1'b1, 8'h66, 1'b1);
        chk("empty_pp_count", 32'(o_count),     32'd1);
        chk("empty_pp_udf",   32'(o_underflow), 32'd1);
        for (int i = 0; i < 40; i++) begin
            mstep(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // 6: async reset mid-burst at count 7
        for (int i = 0; i < 40 && o_count != 0; i++) drive(1'b0, 8'h00, 1'b1);
        chk("pre6_empty", 32'(o_count), 32'd0);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0);
        drive(1'b1, 8'h77, 1'b1);
        chk("pre6_count", 32'(o_count),    32'd7);
        chk("pre6_valid", 32'(o_rd_valid), 32'd1);
        i_push = 1'b1;
        i_wr_data = 8'h78;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(o_count),      32'd0);
        chk("arst_empty", 32'(o_fifo_empty), 32'd1);
        chk("arst_full",  32'(o_fifo_full),  32'd0);
        chk("arst_valid", 32'(o_rd_valid),   32'd0);
        chk("arst_data",  32'(o_rd_data),    32'd0);
        chk("arst_err",   32'(o_err_sticky), 32'd0);
        i_push = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        chk("post_udf",   32'(o_underflow), 32'd1);
        chk("post_valid", 32'(o_rd_valid),  32'd0);
        chk("post_count", 32'(o_count),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
